// File: rtl/audio_sample_fifo_if.sv
// Sample-FIFO bus: producer-side push/flush controls and the FIFO status/level returns.
//   master : drives wr_en, wr_data, flush; observes full, empty, count, level, underflow, overflow
//   slave  : the FIFO side of the same signals
interface audio_sample_fifo_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    level;
    logic          underflow;
    logic          overflow;

    modport master (
        output wr_en, wr_data, flush,
        input  full, empty, count, level, underflow, overflow
    );

    modport slave (
        input  wr_en, wr_data, flush,
        output full, empty, count, level, underflow, overflow
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO: buffers 8-bit samples from the decoder and releases one
// per SAMPLE_DIV clocks onto a registered PWM level.
//   clk  : single clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : slave side of audio_sample_fifo_if (push/flush in, status/level out)
module audio_sample_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SAMPLE_DIV = 750,
    parameter logic [7:0]  MIDSCALE   = 8'h80
) (
    input logic               clk,
    input logic               rstn,
    audio_sample_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 16;

    logic [7:0]    mem [DEPTH];

    logic [DW-1:0] div_q, div_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          overflow_q, overflow_d;

    logic          tick_c;
    logic          pop_c;
    logic          push_c;

    // Tick, pop and push qualification; flush suppresses all of them.
    always_comb begin
        tick_c = (div_q == DW'(SAMPLE_DIV - 1));
        pop_c  = !bus.flush && tick_c && (count_q != '0);
        // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
        push_c = !bus.flush && bus.wr_en && ((count_q < CW'(DEPTH)) || pop_c);
    end

    // Next-state for divider, pointers, occupancy, level and event pulses.
    always_comb begin
        div_d       = div_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        level_d     = level_q;
        underflow_d = 1'b0;
        overflow_d  = 1'b0;

        if (bus.flush) begin
            div_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            level_d  = MIDSCALE;
        end else begin
            div_d = tick_c ? '0 : div_q + DW'(1);
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                level_d  = mem[rd_ptr_q];
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CW'(1);
            end
            // Underflow looks at pre-push occupancy: a push on a tick is not visible to the pop.
            underflow_d = tick_c && (count_q == '0);
            overflow_d  = bus.wr_en && !push_c;
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            level_q     <= MIDSCALE;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Sample storage; never reset, only slots that were written are ever read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.level     = level_q;
    assign bus.underflow = underflow_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed scenarios plus a random
// push/flush soak, all compared against a queue-based reference model.
module tb_audio_sample_fifo;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned SAMPLE_DIV = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    audio_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

    audio_sample_fifo #(
        .DEPTH     (DEPTH),
        .SAMPLE_DIV(SAMPLE_DIV),
        .MIDSCALE  (8'h80)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: sample queue, output level, pulses, cycles since reset/flush.
    logic [7:0]  m_q [$];
    logic [7:0]  m_level;
    bit          m_uf;
    bit          m_of;
    int unsigned m_cycles;

    int unsigned uf_seen;
    logic [7:0]  last_level;
    logic [7:0]  lvl_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_level  = 8'h80;
        m_uf     = 1'b0;
        m_of     = 1'b0;
        m_cycles = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit we, input logic [7:0] wd, input bit fl);
        bit tick;
        if (fl) begin
            model_reset();
            return;
        end
        tick = ((m_cycles % SAMPLE_DIV) == SAMPLE_DIV - 1);
        m_cycles++;
        m_uf = tick && (m_q.size() == 0);
        if (tick && m_q.size() > 0) m_level = m_q.pop_front();
        m_of = 1'b0;
        if (we) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else                    m_of = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("level",     32'(bus.level),     32'(m_level));
        chk("count",     32'(bus.count),     32'(m_q.size()));
        chk("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
        chk("empty",     32'(bus.empty),     32'(m_q.size() == 0));
        chk("underflow", 32'(bus.underflow), 32'(m_uf));
        chk("overflow",  32'(bus.overflow),  32'(m_of));
    endtask

    // Called at a negedge: drive inputs, take one edge, check at the next negedge.
    task automatic step(input bit we, input logic [7:0] wd, input bit fl);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.flush   = fl;
        @(posedge clk);
        model_step(we, wd, fl);
        @(negedge clk);
        check_outputs();
        if (bus.underflow === 1'b1) uf_seen++;
        if (bus.level !== last_level) begin
            lvl_log.push_back(bus.level);
            last_level = bus.level;
        end
    endtask

    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs();
        rstn = 1'b1;
        uf_seen    = 0;
        last_level = 8'h80;
        lvl_log.delete();
    endtask

    initial begin
        logic [7:0] exp_seq [6];
        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;
        model_reset();
        @(negedge clk);

        // Idle after reset: underflow every SAMPLE_DIV cycles, level at midscale.
        do_reset();
        repeat (20) step(1'b0, 8'h00, 1'b0);
        chk("idle_uf_pulses", 32'(uf_seen), 32'd5);
        chk("idle_level", 32'(bus.level), 32'h80);

        // Three pushes drain one per tick, then underflow with level held.
        do_reset();
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h30, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("drain_first", 32'(bus.level), 32'h10);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("drain_second", 32'(bus.level), 32'h20);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("drain_third", 32'(bus.level), 32'h30);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("drain_uf_once", 32'(uf_seen), 32'd1);
        chk("drain_hold", 32'(bus.level), 32'h30);

        // Fill to full, overflow drops, then push on a tick while full.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 5) chk("fill_full", 32'(bus.full), 32'd1);
            if (i == 6) chk("fill_overflow", 32'(bus.overflow), 32'd1);
        end
        step(1'b1, 8'hAA, 1'b0);
        chk("tickpush_count", 32'(bus.count), 32'd4);
        chk("tickpush_no_of", 32'(bus.overflow), 32'd0);
        repeat (16) step(1'b0, 8'h00, 1'b0);
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hAA};
        chk("order_len", 32'(lvl_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < lvl_log.size()) chk("order_item", 32'(lvl_log[i]), 32'(exp_seq[i]));
        end

        // Flush with entries queued and wr_en high, coinciding with a tick.
        do_reset();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_level", 32'(bus.level), 32'h80);
        chk("flush_no_uf", 32'(bus.underflow), 32'd0);
        uf_seen = 0;
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("flush_no_early_uf", 32'(uf_seen), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("flush_tick_uf", 32'(bus.underflow), 32'd1);

        // Asynchronous reset between edges with samples queued.
        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h6B, 1'b0);
        step(1'b1, 8'h7C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_level", 32'(bus.level), 32'h80);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_full",  32'(bus.full),  32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_uf",    32'(bus.underflow), 32'd0);
        chk("arst_of",    32'(bus.overflow),  32'd0);
        @(negedge clk);
        model_reset();
        rstn       = 1'b1;
        last_level = 8'h80;

        // Random soak against the reference model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                 8'($urandom()),
                 ($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 Parameter SAMPLE_DIV, default 750: clk cycles per output sample (24 MHz / 750 = 32 kHz); 2..65535.
REQ-003 Parameter MIDSCALE, default 8'h80: idle PWM level.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  push wr_data this cycle; driven by the video decoder's sample strobe.
REQ-007 wr_data  input  8  unsigned 8-bit audio sample.
REQ-008 flush  input  1  synchronous clear; tied to frame restart / stop_data.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 level  output  8  registered sample to pwm_ctrl level input.
REQ-013 underflow  output  1  one-cycle pulse: sample tick found FIFO empty.
REQ-014 overflow  output  1  one-cycle pulse: push dropped because full.

Function
REQ-015 Divider counts 0..SAMPLE_DIV-1, wraps to 0; tick is asserted in the cycle divider == SAMPLE_DIV-1.
REQ-016 Pop occurs on tick when count > 0; level takes the head entry on that same edge (visible the cycle after tick).
REQ-017 Tick with count == 0: level holds its previous value; underflow pulses in the following cycle; no pointer change.
REQ-018 Push occurs when wr_en=1 and (count < DEPTH or a pop occurs in the same cycle).
REQ-019 wr_en=1 while full with no same-cycle pop: data discarded, contents unchanged, overflow pulses next cycle.
REQ-020 Simultaneous push and pop: both performed, count unchanged; when full, the new entry goes into the slot just freed.
REQ-021 Push into an empty FIFO on a tick cycle: push accepted; the pop does not see the new entry; underflow pulses.
REQ-022 Storage is circular; read/write pointers wrap modulo DEPTH; count is exact, with no one-slot-lost scheme.
REQ-023 full = (count == DEPTH) and empty = (count == 0), both registered and consistent with count every cycle.
REQ-024 Order preserved: samples leave in push order, none duplicated or skipped except per REQ-019.
REQ-025 flush=1: next edge sets count 0, pointers 0, level MIDSCALE, divider 0; wr_en in that cycle is ignored; no underflow/overflow pulse.
REQ-026 flush takes priority over push, pop and tick in the same cycle.
REQ-027 underflow and overflow never stay high for two consecutive cycles from a single event.

Reset
REQ-028 rstn low asynchronously forces: count 0, pointers 0, divider 0, level MIDSCALE, full 0, empty 1, underflow 0, overflow 0.
REQ-029 Storage contents need no reset; unread storage never reaches level.
REQ-030 After rstn deassertion, first tick is exactly SAMPLE_DIV cycles later.
REQ-031 Reset mid-operation discards all queued samples; behaviour afterwards is identical to power-up.

Verification (bench with DEPTH=4, SAMPLE_DIV=4)
REQ-032 Reset, idle 20 cycles -> level=8'h80, empty=1, underflow pulses once every 4 cycles from cycle 4.
REQ-033 Push 8'h10,8'h20,8'h30 back-to-back after reset -> level becomes 10,20,30 at successive ticks, then underflow, level holds 30.
REQ-034 Push 5 samples 01..05 with no tick in between -> full=1 after 4, overflow pulse on 5th, output sequence 01..04.
REQ-035 Full FIFO, push 8'hAA on a tick cycle -> count stays 4, no overflow, AA emerges fourth.
REQ-036 Assert flush with 3 entries queued and wr_en=1 -> count 0, level 80, next tick 4 cycles later underflows.
REQ-037 Drop rstn mid-stream between edges -> outputs reach reset values without a clock edge; random push/tick soak against a reference queue model for 10k cycles with zero mismatches.
